// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   uart_state_e : frame FSM states
//   DATA_BITS    : payload bits per frame
//   START_BIT    : line level of the start bit
//   STOP_BIT     : line level of the stop bit (also the idle level)
package uart_pkg;

    localparam int   DATA_BITS = 8;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding the UART transmitter.
//   clk, reset_n : clock, async active-low reset (empties the FIFO)
//   push, push_data : write request/data; ignored while full
//   pop, pop_data   : read request; pop_data shows the head (valid when !empty)
//   full, empty     : registered status flags
module uart_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic       full,
    output logic       empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          push_ok;
    logic          pop_ok;

    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_nxt = count;
        if (push_ok && !pop_ok)
            count_nxt = count + CW'(1);
        else if (!push_ok && pop_ok)
            count_nxt = count - CW'(1);
    end

    // Storage needs no reset; only pointers and flags define the contents.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= push_data;
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter: FIFO-buffered 8N1 (optionally 8E1) UART transmitter.
//   clk, reset_n : clock, async active-low reset (aborts any frame)
//   data_in, valid, ready : byte input; accepted when valid && ready
//   tx   : registered serial line, idle high
//   busy : FSM active or bytes still queued
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 3,
    parameter int PARITY_EN    = 0,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] data_in,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    uart_state_e   state;
    logic [CW-1:0] bit_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          par_q;
    logic          bit_done;
    logic          pop;
    logic [7:0]    fifo_data;
    logic          fifo_full;
    logic          fifo_empty;

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (valid),
        .push_data (data_in),
        .pop       (pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign ready    = !fifo_full;
    assign busy     = (state != IDLE) || !fifo_empty;
    assign bit_done = (bit_cnt == CW'(CLKS_PER_BIT - 1));

    // Pop from IDLE, or at the end of a stop bit so frames run back to back.
    assign pop = !fifo_empty && ((state == IDLE) || (state == STOP && bit_done));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            par_q   <= 1'b0;
            tx      <= STOP_BIT;
        end else begin
            // Bit timer only runs inside a frame; it is 0 on entry to START.
            if (state != IDLE)
                bit_cnt <= bit_done ? '0 : bit_cnt + CW'(1);

            // Parity is taken from the whole byte at load time because
            // the shift register is consumed during DATA.
            if (pop) begin
                shreg <= fifo_data;
                par_q <= ^fifo_data;
                tx    <= START_BIT;
                state <= START;
            end

            unique case (state)
                IDLE: ;
                START: if (bit_done) begin
                    state   <= DATA;
                    bit_idx <= '0;
                    tx      <= shreg[0];
                end
                DATA: if (bit_done) begin
                    if (bit_idx == 3'(DATA_BITS - 1)) begin
                        if (PARITY_EN != 0) begin
                            state <= PARITY;
                            tx    <= par_q;
                        end else begin
                            state <= STOP;
                            tx    <= STOP_BIT;
                        end
                    end else begin
                        bit_idx <= bit_idx + 3'd1;
                        shreg   <= shreg >> 1;
                        tx      <= shreg[1];
                    end
                end
                PARITY: if (bit_done) begin
                    state <= STOP;
                    tx    <= STOP_BIT;
                end
                STOP: if (bit_done && !pop)
                    state <= IDLE;
                default: begin
                    state <= IDLE;
                    tx    <= STOP_BIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: randomized check of uart_transmitter against a
// cycle-level frame schedule model (accept time -> frame start time -> line).
module tb_uart_transmitter;

    localparam int CPB   = 3;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] data_in;
    logic       valid;
    logic       ready, tx, busy;
    logic [7:0] pdata;
    logic       pvalid;
    logic       pready, ptx, pbusy;

    always #5 clk = ~clk;

    uart_transmitter #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .FIFO_DEPTH(DEPTH)) u_dut (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .valid(valid),
        .ready(ready), .tx(tx), .busy(busy)
    );

    uart_transmitter #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .FIFO_DEPTH(DEPTH)) u_par (
        .clk(clk), .reset_n(reset_n), .data_in(pdata), .valid(pvalid),
        .ready(pready), .tx(ptx), .busy(pbusy)
    );

    typedef struct {
        int         start;
        logic [7:0] b;
    } frame_t;

    frame_t fq[$];
    int     line_free = 0;
    int     cyc = 0;
    int     npass = 0;
    int     ntotal = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntotal++;
        if (got !== exp)
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        else
            npass++;
    endtask

    // Bytes accepted but not yet started at time t (i.e. still in the FIFO).
    function automatic int queued_at(int t);
        int n = 0;
        foreach (fq[i]) if (fq[i].start > t) n++;
        return n;
    endfunction

    function automatic logic exp_tx(int t);
        foreach (fq[i]) begin
            if (t >= fq[i].start && t < fq[i].start + FRAME) begin
                int k = (t - fq[i].start) / CPB;
                if (k == 0) return 1'b0;
                if (k <= 8) return fq[i].b[k-1];
                return 1'b1;
            end
        end
        return 1'b1;
    endfunction

    function automatic logic exp_busy(int t);
        foreach (fq[i])
            if (t >= fq[i].start && t < fq[i].start + FRAME) return 1'b1;
        return queued_at(t) > 0;
    endfunction

    // Called at a falling edge: drive inputs, update the model, advance one
    // cycle, then compare all outputs at the next falling edge.
    task automatic step(input logic v, input logic [7:0] d);
        frame_t f;
        valid   = v;
        data_in = d;
        if (v && queued_at(cyc) < DEPTH) begin
            f.start = (cyc + 2 > line_free) ? cyc + 2 : line_free;
            f.b     = d;
            fq.push_back(f);
            line_free = f.start + FRAME;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        chk("tx", tx, exp_tx(cyc));
        chk("ready", ready, queued_at(cyc) < DEPTH);
        chk("busy", busy, exp_busy(cyc));
    endtask

    task automatic send_par(input logic [7:0] b);
        logic e;
        chk("p_ready", pready, 1);
        pvalid = 1'b1;
        pdata  = b;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        pvalid = 1'b0;
        pdata  = ~b;
        chk("p_tx_idle", ptx, 1);
        for (int j = 0; j < 11 * CPB; j++) begin
            int k = j / CPB;
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (k == 0)      e = 1'b0;
            else if (k <= 8) e = b[k-1];
            else if (k == 9) e = ^b;
            else             e = 1'b1;
            chk(k == 9 ? "p_parity" : "p_tx", ptx, e);
            chk("p_busy", pbusy, 1);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        chk("p_tx_end", ptx, 1);
        chk("p_busy_end", pbusy, 0);
    endtask

    initial begin
        logic [7:0] hb [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        int idx;
        int s;
        logic r;

        reset_n = 1'b0;
        valid   = 1'b0;
        data_in = 8'h00;
        pvalid  = 1'b0;
        pdata   = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ptx", ptx, 1);
        reset_n = 1'b1;
        cyc = 0;

        // Single byte from idle, then drain.
        step(1, 8'hD5);
        for (int i = 0; i < 40; i++) step(0, 8'($urandom));

        // Back-to-back bytes: two contiguous frames.
        step(1, 8'hD5);
        step(1, 8'h33);
        for (int i = 0; i < 70; i++) step(0, 8'($urandom));

        // Hold valid with six distinct bytes; FIFO fills after five.
        idx = 0;
        for (int i = 0; i < 200; i++) begin
            r = ready;
            step(idx < 6, (idx < 6) ? hb[idx] : 8'($urandom));
            if (idx < 6 && r) idx++;
            if (i == 4) begin
                chk("acc5", idx, 5);
                chk("rdy_full", ready, 0);
            end
        end
        chk("acc6", idx, 6);

        // Random traffic, data_in wandering while not accepted.
        for (int i = 0; i < 800; i++)
            step($urandom_range(0, 9) < 4, 8'($urandom));
        for (int i = 0; i < 160; i++) step(0, 8'($urandom));

        // Reset in data bit 3 of a frame with two more bytes queued.
        step(1, 8'hF0);
        step(1, 8'hA5);
        step(1, 8'h5A);
        s = fq[fq.size()-3].start;
        for (int i = 0; i < 40 && cyc < s + 4 * CPB + 1; i++) step(0, 8'($urandom));
        chk("pre_rst_tx", tx, 0);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_tx", tx, 1);
        chk("mid_rst_ready", ready, 1);
        chk("mid_rst_busy", busy, 0);
        fq.delete();
        line_free = 0;
        repeat (2) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        chk("hold_rst_tx", tx, 1);
        reset_n = 1'b1;
        for (int i = 0; i < 100; i++) step(0, 8'($urandom));

        // Parity variant.
        send_par(8'h07);
        send_par(8'h03);
        for (int i = 0; i < 20; i++) begin
            send_par(8'($urandom));
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 3, meaning clk cycles per serial bit, legal values 2 or more.
REQ-002 The block SHALL have parameter PARITY_EN, default 0, meaning 1 inserts an even-parity bit after the data bits.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, meaning input byte FIFO entries, a power of two and 2 or more.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 data_in  input  8  byte to transmit.
REQ-007 valid  input  1  data_in is valid; a byte is accepted on a rising edge where valid and ready are both 1.
REQ-008 ready  output  1  FIFO can accept a byte; registered; equals NOT full.
REQ-009 tx  output  1  serial line, idle high; registered, glitch-free; connects directly to the uart_receiver rx input.
REQ-010 busy  output  1  high while the FSM is not in IDLE or the FIFO is non-empty.

Function
REQ-011 The frame SHALL be: start bit 0, 8 data bits LSB first, the parity bit (only when PARITY_EN=1) equal to the XOR of the data bits, then stop bit 1.
REQ-012 Each bit SHALL hold tx for exactly CLKS_PER_BIT cycles, timed by a bit counter that wraps from CLKS_PER_BIT-1 to 0.
REQ-013 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP.
REQ-014 IDLE -> START when the FIFO is non-empty: pop the head into the shift register; tx=0 from the same edge.
REQ-015 START -> DATA when the bit counter expires.
REQ-016 DATA SHALL shift out 8 bits, tracked by a 3-bit index, then go to PARITY if PARITY_EN=1, otherwise to STOP.
REQ-017 PARITY -> STOP when the bit counter expires.
REQ-018 STOP SHALL hold tx=1 for one bit time, then go to START if the FIFO is non-empty (pop on that edge, no idle gap), otherwise to IDLE.
REQ-019 Latency: a byte accepted at edge N into an empty FIFO with the FSM in IDLE SHALL drive tx=0 from edge N+1.
REQ-020 Frame length SHALL be 10*CLKS_PER_BIT cycles, or 11*CLKS_PER_BIT cycles with parity.
REQ-021 Push and pop in the same cycle SHALL be allowed when not full; the count is unchanged.
REQ-022 When full, valid SHALL be ignored, with no overwrite; ready returns high the cycle after a pop.
REQ-023 Bytes SHALL be transmitted in acceptance order, and FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-024 data_in SHALL be captured only on acceptance; later changes to data_in do not affect queued bytes.

Reset
REQ-025 While reset_n=0: tx=1, ready=1, busy=0, state IDLE, FIFO empty, and all counters 0, applied asynchronously.
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately (tx=1) and discard all queued bytes.
REQ-027 After reset_n rises, no frame SHALL start until a new byte is accepted.

Structure
REQ-028 Shared package uart_pkg SHALL hold the FSM state enum and the constants DATA_BITS=8, START_BIT=0 and STOP_BIT=1, for reuse by uart_receiver.
REQ-029 The FIFO SHALL be a sub-module, uart_tx_fifo, with push/pop/full/empty and data ports and parameter DEPTH.
REQ-030 The FSM, bit counter, bit index and shift register SHALL reside in uart_transmitter.

Verification (10 ns clk, CLKS_PER_BIT=3 unless stated)
REQ-031 Push 0xD5 from idle -> tx segments 0,1,0,1,0,1,0,1,1,1, each 3 cycles (30 cycles total); a looped-back uart_receiver reports data=0xD5 with ready=1.
REQ-032 Push 0xD5 then 0x33 on consecutive cycles -> two frames in 60 contiguous cycles with no idle gap; the receiver reports 0xD5 then 0x33.
REQ-033 Hold valid=1 from idle with 6 distinct bytes -> 5 bytes accepted and ready=0 at the 5th edge; all 5 are transmitted in order; busy falls 1 cycle after the last stop bit.
REQ-034 PARITY_EN=1, push 0x07 -> 11-bit frame with parity bit 1; push 0x03 -> parity bit 0.
REQ-035 Drop reset_n during data bit 3 with 2 bytes queued -> tx=1 within the same cycle; after release tx stays 1 and busy=0 for 100 cycles.
